mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning word address width; the memory holds 2^ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, meaning the number of independent request channels.
REQ-004 SHALL have parameter LATENCY, default 2, legal range 1..15, meaning busy cycles per accepted request.
REQ-005 SHALL have parameter WRITE_ENABLE, default 1; when 0, the write path is tied off.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port mem_read_valid, input, [NUM_CHANNELS]: read request per channel.
REQ-009 SHALL have port mem_read_address, input, [NUM_CHANNELS][ADDR_BITS]: read address per channel.
REQ-010 SHALL have port mem_read_ready, output, [NUM_CHANNELS]: read engine idle and able to accept.
REQ-011 SHALL have port mem_read_data, output, [NUM_CHANNELS][DATA_BITS]: last completed read word, held stable.
REQ-012 SHALL have port mem_read_done, output, [NUM_CHANNELS]: one-cycle pulse when read data becomes valid.
REQ-013 SHALL have ports mem_write_valid, input, [NUM_CHANNELS]; mem_write_address, input, [NUM_CHANNELS][ADDR_BITS]; mem_write_data, input, [NUM_CHANNELS][DATA_BITS]; mem_write_ready, output, [NUM_CHANNELS].

Function
REQ-014 Each channel SHALL run independent read and write engines, each with states IDLE and BUSY and a 4-bit down-counter.
REQ-015 Accept SHALL occur when valid && ready are both high at a rising edge; in IDLE, ready=1, and in BUSY, ready=0.
REQ-016 On a read accept, the engine SHALL sample array[address] at that edge, enter BUSY, and load the counter with LATENCY-1.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at counter==0, the engine SHALL return to IDLE, drive mem_read_data with the sampled word, and pulse mem_read_done for exactly that cycle.
REQ-018 Read data SHALL therefore be visible LATENCY cycles after the accept edge, and SHALL persist until the next completion on that channel.
REQ-019 A valid asserted in the IDLE cycle that coincides with completion SHALL be accepted, giving back-to-back throughput of one request per LATENCY+1 cycles.
REQ-020 On a write accept, the array SHALL be updated at the accept edge, and the engine SHALL be BUSY for LATENCY cycles with no completion pulse.
REQ-021 For simultaneous writes to the same address from multiple channels, the lowest channel index SHALL win.
REQ-022 For a read and a write to the same address at the same edge, the read SHALL return the old value.
REQ-023 Valid deasserted while BUSY SHALL have no effect, because a request is never cancelled once accepted.
REQ-024 When WRITE_ENABLE=0, mem_write_ready SHALL be 0 constantly, and writes SHALL be ignored.

Reset
REQ-025 While reset=0, the block SHALL drive: all engines IDLE, counters 0, mem_read_ready all-ones, mem_write_ready all-ones (zeros if WRITE_ENABLE=0), mem_read_data 0, and mem_read_done 0.
REQ-026 Assertion of reset mid-operation SHALL abort all in-flight requests immediately with no done pulse; array contents are not reset.

Configuration
REQ-027 With MEM_RESP_STATS_EN defined, the block SHALL add outputs stat_reads[16] and stat_writes[16], which SHALL count accepts summed over all channels per cycle, saturate at 16'hFFFF, and reset to 0.
REQ-028 Without MEM_RESP_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-029 Package gpu_mem_pkg SHALL hold the engine state enum (IDLE, BUSY) and the LATENCY counter width constant (4).
REQ-030 Sub-module mem_resp_engine SHALL implement one IDLE/BUSY engine, instantiated 2*NUM_CHANNELS times.
REQ-031 The storage array and the write-priority resolution SHALL live in the top-level mem_responder module.

Verification
REQ-032 Write test: channel 0 writes addr 8'h10 data 8'hA5 at cycle 0; mem_write_ready[0]=0 for cycles 1-2; channel 1 read of 8'h10 accepted at cycle 1 -> mem_read_done[1] pulses at cycle 3 with data 8'hA5.
REQ-033 Back-to-back test: channel 2 holds read valid continuously on addresses 0,1,2 -> accepts at cycles 0, 3, 6 and done pulses at cycles 2, 5, 8 (LATENCY=2).
REQ-034 Write collision test: channels 0 and 3 write addr 8'h20 with 8'h11 and 8'h33 at the same edge -> a subsequent read returns 8'h11.
REQ-035 Read/write collision test: addr 8'h30 holds 8'h01; read and write of 8'h02 occur at the same edge -> the read returns 8'h01, and the next read returns 8'h02.
REQ-036 Mid-operation reset test: reset is pulsed low one cycle after a read accept -> no done pulse, ready all-ones, and mem_read_data 0.
REQ-037 Stats test: with MEM_RESP_STATS_EN defined, 4 channels read simultaneously for 3 rounds -> stat_reads=12 and stat_writes=0.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared engine state type, counter width and stats helper
// for the mem_responder slice.
package gpu_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } eng_state_t;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_add(
    input logic [STAT_W-1:0] a,
    input logic [STAT_W-1:0] b
  );
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/mem_resp_engine.sv
// mem_resp_engine: one IDLE/BUSY request engine with a latency
// down-counter; o_last flags the final busy cycle.
module mem_resp_engine
  import gpu_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_valid,
  output logic o_ready,
  output logic o_accept,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  eng_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  assign o_ready  = i_en && (r_state == IDLE);
  assign o_accept = i_valid && o_ready;
  assign o_last   = (r_state == BUSY) && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (o_accept) begin
            r_state <= BUSY;
            r_cnt   <= LOAD;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-channel latency-modelled memory responder.
// Optional accept counters enabled by defining MEM_RESP_STATS_EN.
module mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_read_done,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
`ifdef MEM_RESP_STATS_EN
  output logic [STAT_W-1:0]                       stat_reads,
  output logic [STAT_W-1:0]                       stat_writes,
`endif
  output logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int   DEPTH = 1 << ADDR_BITS;
  localparam logic W_EN  = (WRITE_ENABLE != 0);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  logic [NUM_CHANNELS-1:0] w_rd_acc;
  logic [NUM_CHANNELS-1:0] w_rd_last;
  logic [NUM_CHANNELS-1:0] w_wr_acc;
  logic [NUM_CHANNELS-1:0] w_wr_last_unused;

  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_sample;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_rdata;
  logic [NUM_CHANNELS-1:0]                r_done;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_resp_engine #(.LATENCY(LATENCY)) u_rd (
      .clk      (clk),
      .reset    (reset),
      .i_en     (1'b1),
      .i_valid  (mem_read_valid[c]),
      .o_ready  (mem_read_ready[c]),
      .o_accept (w_rd_acc[c]),
      .o_last   (w_rd_last[c])
    );
    mem_resp_engine #(.LATENCY(LATENCY)) u_wr (
      .clk      (clk),
      .reset    (reset),
      .i_en     (W_EN),
      .i_valid  (mem_write_valid[c]),
      .o_ready  (mem_write_ready[c]),
      .o_accept (w_wr_acc[c]),
      .o_last   (w_wr_last_unused[c])
    );
  end

  // Descending loop: the lowest channel's write lands last and wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
        if (w_wr_acc[c]) begin
          r_mem[mem_write_address[c]] <= mem_write_data[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample <= '0;
      r_rdata  <= '0;
      r_done   <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_done[c] <= w_rd_last[c];
        if (w_rd_acc[c]) begin
          r_sample[c] <= r_mem[mem_read_address[c]];
        end
        if (w_rd_last[c]) begin
          r_rdata[c] <= r_sample[c];
        end
      end
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_read_done = r_done;

`ifdef MEM_RESP_STATS_EN
  logic [STAT_W-1:0] r_stat_rd;
  logic [STAT_W-1:0] r_stat_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else begin
      r_stat_rd <= sat_add(r_stat_rd, STAT_W'($countones(w_rd_acc)));
      r_stat_wr <= sat_add(r_stat_wr, STAT_W'($countones(w_wr_acc)));
    end
  end

  assign stat_reads  = r_stat_rd;
  assign stat_writes = r_stat_wr;
`endif

endmodule
